// File: rtl/mem_stage_mq_pkg.sv
// Shared definitions for the multi-outstanding MEM stage.
// Load opcode bit positions match the one-hot load_op vector used by EXE/WB.
package mem_stage_mq_pkg;

    localparam int unsigned LOAD_OP_W = 5;

    localparam int unsigned LD_B  = 0;
    localparam int unsigned LD_H  = 1;
    localparam int unsigned LD_W  = 2;
    localparam int unsigned LD_BU = 3;
    localparam int unsigned LD_HU = 4;

endpackage

// File: rtl/mem_stage_mq_load_align.sv
// Load data formatting for the MEM stage.
// Ports:
//   rdata   - raw word returned by data_sram
//   offset  - byte offset of the access (exe_result[1:0])
//   load_op - one-hot load type (LD_B/LD_H/LD_W/LD_BU/LD_HU)
//   result  - aligned and sign/zero-extended load value
module mem_stage_mq_load_align
    import mem_stage_mq_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]    rdata,
    input  logic [1:0]           offset,
    input  logic [LOAD_OP_W-1:0] load_op,
    output logic [DATA_W-1:0]    result
);

    logic [DATA_W-1:0] shifted;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        result  = rdata;
        if (load_op[LD_B]) begin
            result = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
        end else if (load_op[LD_BU]) begin
            result = {{(DATA_W-8){1'b0}}, shifted[7:0]};
        end else if (load_op[LD_H]) begin
            result = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
        end else if (load_op[LD_HU]) begin
            result = {{(DATA_W-16){1'b0}}, shifted[15:0]};
        end
    end

endmodule

// File: rtl/mem_stage_mq.sv
// Multi-outstanding MEM stage.
// Queues up to DEPTH instructions from EXE, matches in-order data_sram data_ok
// responses to the entries waiting for one, and retires entries in order to WB
// with load alignment applied. Responses belonging to flushed entries are
// absorbed by an internal cancel counter.
// Ports:
//   clk, resetn          - clock, asynchronous active-low reset
//   in_valid/in_allowin  - EXE handshake; in_allowin = queue not full
//   in_payload           - opaque side payload carried to WB
//   in_need_resp         - entry waits for one data_ok
//   in_load_op           - one-hot load type, zero for non-loads
//   in_result            - exe_result; [1:0] is the byte offset for loads
//   data_ok, rdata       - data_sram response (in request order)
//   out_valid/out_allowin- WB handshake for the head entry
//   out_payload/out_result - head entry payload and (formatted) result
//   flush                - discard every queued entry
//   count                - number of valid entries
//   cancel_busy          - responses of flushed entries still expected
//   err_spurious         - sticky: data_ok that matched nothing
module mem_stage_mq
    import mem_stage_mq_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PTR_W     = 2,
    parameter int unsigned PAYLOAD_W = 200,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 in_valid,
    output logic                 in_allowin,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic                 in_need_resp,
    input  logic [LOAD_OP_W-1:0] in_load_op,
    input  logic [DATA_W-1:0]    in_result,
    input  logic                 data_ok,
    input  logic [DATA_W-1:0]    rdata,
    output logic                 out_valid,
    input  logic                 out_allowin,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [DATA_W-1:0]    out_result,
    input  logic                 flush,
    output logic [PTR_W:0]       count,
    output logic                 cancel_busy,
    output logic                 err_spurious
);

    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DEPTH-1:0]     q_valid;
    logic [DEPTH-1:0]     q_need;
    logic [DEPTH-1:0]     q_got;
    logic [LOAD_OP_W-1:0] q_load_op [DEPTH];
    logic [DATA_W-1:0]    q_result  [DEPTH];
    logic [PAYLOAD_W-1:0] q_payload [DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   cancel_cnt;
    logic             err_q;

    logic             enq;
    logic             deq;
    logic             head_ready;
    logic [DEPTH-1:0] pending;
    logic             resp_found;
    logic [PTR_W-1:0] resp_ptr;
    logic [PTR_W:0]   outstanding;
    logic             resp_take;
    logic             spurious;
    logic [PTR_W+1:0] cancel_sum;
    logic [PTR_W:0]   flush_cancel;
    logic [DATA_W-1:0] aligned;

    assign in_allowin   = (count_q != CNT_FULL);
    assign enq          = in_valid && in_allowin && !flush;
    assign head_ready   = q_valid[head] && (!q_need[head] || q_got[head]);
    assign deq          = head_ready && out_allowin && !flush;
    assign pending      = q_valid & q_need & ~q_got;

    // resp_ptr is derived each cycle by scanning from head in age order:
    // the oldest entry still waiting for data is the one the next data_ok
    // belongs to, which naturally skips entries that need no response.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx         = head;
        resp_found  = 1'b0;
        resp_ptr    = head;
        outstanding = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (pending[idx]) begin
                outstanding = outstanding + CNT_ONE;
                if (!resp_found) begin
                    resp_found = 1'b1;
                    resp_ptr   = idx;
                end
            end
        end
    end

    assign resp_take = data_ok && (cancel_cnt == '0) && resp_found && !flush;
    assign spurious  = data_ok && (cancel_cnt == '0) && !resp_found;

    // On flush the in-flight data_ok (if any) retires one of the currently
    // outstanding responses; the rest must be absorbed later.
    always_comb begin
        cancel_sum   = {1'b0, cancel_cnt} + {1'b0, outstanding};
        flush_cancel = (data_ok && (cancel_sum != '0))
                     ? (PTR_W+1)'(cancel_sum - (PTR_W+2)'(1))
                     : (PTR_W+1)'(cancel_sum);
    end

    mem_stage_mq_load_align #(
        .DATA_W(DATA_W)
    ) u_load_align (
        .rdata  (rdata),
        .offset (q_result[resp_ptr][1:0]),
        .load_op(q_load_op[resp_ptr]),
        .result (aligned)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            q_valid    <= '0;
            q_need     <= '0;
            q_got      <= '0;
            head       <= '0;
            tail       <= '0;
            count_q    <= '0;
            cancel_cnt <= '0;
            err_q      <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                q_load_op[i] <= '0;
                q_result[i]  <= '0;
                q_payload[i] <= '0;
            end
        end else begin
            if (spurious) begin
                err_q <= 1'b1;
            end
            if (flush) begin
                q_valid    <= '0;
                q_need     <= '0;
                q_got      <= '0;
                head       <= '0;
                tail       <= '0;
                count_q    <= '0;
                cancel_cnt <= flush_cancel;
            end else begin
                if (data_ok && (cancel_cnt != '0)) begin
                    cancel_cnt <= cancel_cnt - CNT_ONE;
                end
                if (resp_take) begin
                    q_got[resp_ptr] <= 1'b1;
                    if (|q_load_op[resp_ptr]) begin
                        q_result[resp_ptr] <= aligned;
                    end
                end
                if (deq) begin
                    q_valid[head] <= 1'b0;
                    head          <= head + PTR_ONE;
                end
                if (enq) begin
                    q_valid[tail]   <= 1'b1;
                    q_need[tail]    <= in_need_resp;
                    q_got[tail]     <= 1'b0;
                    q_load_op[tail] <= in_load_op;
                    q_result[tail]  <= in_result;
                    q_payload[tail] <= in_payload;
                    tail            <= tail + PTR_ONE;
                end
                case ({enq, deq})
                    2'b10:   count_q <= count_q + CNT_ONE;
                    2'b01:   count_q <= count_q - CNT_ONE;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    assign out_valid    = head_ready;
    assign out_payload  = q_valid[head] ? q_payload[head] : '0;
    assign out_result   = q_valid[head] ? q_result[head]  : '0;
    assign count        = count_q;
    assign cancel_busy  = (cancel_cnt != '0);
    assign err_spurious = err_q;

endmodule

// File: tb/tb_mem_stage_mq.sv
// Self-checking bench for mem_stage_mq: directed scenarios followed by random
// traffic, all compared against a transaction-queue reference model.
module tb_mem_stage_mq;
    import mem_stage_mq_pkg::*;

    localparam int DEPTH     = 4;
    localparam int PTR_W     = 2;
    localparam int PAYLOAD_W = 200;
    localparam int DATA_W    = 32;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic                 in_valid;
    logic                 in_allowin;
    logic [PAYLOAD_W-1:0] in_payload;
    logic                 in_need_resp;
    logic [4:0]           in_load_op;
    logic [DATA_W-1:0]    in_result;
    logic                 data_ok;
    logic [DATA_W-1:0]    rdata;
    logic                 out_valid;
    logic                 out_allowin;
    logic [PAYLOAD_W-1:0] out_payload;
    logic [DATA_W-1:0]    out_result;
    logic                 flush;
    logic [PTR_W:0]       count;
    logic                 cancel_busy;
    logic                 err_spurious;

    always #5 clk = ~clk;

    mem_stage_mq #(
        .DEPTH(DEPTH),
        .PTR_W(PTR_W),
        .PAYLOAD_W(PAYLOAD_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_allowin(in_allowin), .in_payload(in_payload),
        .in_need_resp(in_need_resp), .in_load_op(in_load_op), .in_result(in_result),
        .data_ok(data_ok), .rdata(rdata),
        .out_valid(out_valid), .out_allowin(out_allowin),
        .out_payload(out_payload), .out_result(out_result),
        .flush(flush), .count(count), .cancel_busy(cancel_busy),
        .err_spurious(err_spurious)
    );

    typedef struct {
        logic [PAYLOAD_W-1:0] payload;
        bit                   need;
        logic [4:0]           lop;
        logic [31:0]          result;
        bit                   got;
    } ent_t;

    ent_t mq[$];
    int   m_cancel;
    bit   m_err;
    int   checks;
    int   errors;

    // Reference load formatting from the ISA rules, using plain arithmetic.
    function automatic logic [31:0] fmt(logic [31:0] rd, int off, logic [4:0] lop);
        int unsigned b;
        int unsigned h;
        b = (rd >> (off * 8)) % 256;
        h = (rd >> (off * 8)) % 65536;
        if (lop[LD_B])  return (b >= 128)   ? b - 256   : b;
        if (lop[LD_BU]) return b;
        if (lop[LD_H])  return (h >= 32768) ? h - 65536 : h;
        if (lop[LD_HU]) return h;
        return rd;
    endfunction

    function automatic logic [PAYLOAD_W-1:0] rand_payload();
        logic [223:0] w;
        for (int i = 0; i < 7; i++) w[i*32 +: 32] = $urandom();
        return w[PAYLOAD_W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_outstanding();
        int n;
        n = 0;
        foreach (mq[i]) if (mq[i].need && !mq[i].got) n++;
        return n;
    endfunction

    task automatic check_outputs();
        bit ev;
        ev = (mq.size() > 0) && (!mq[0].need || mq[0].got);
        chk("out_valid",    out_valid,    ev);
        chk("count",        count,        mq.size());
        chk("in_allowin",   in_allowin,   mq.size() < DEPTH);
        chk("cancel_busy",  cancel_busy,  m_cancel != 0);
        chk("err_spurious", err_spurious, m_err);
        if (mq.size() == 0) begin
            chk("empty_result",  out_result,  0);
            chk("empty_payload", out_payload, 0);
        end else if (ev) begin
            chk("out_result",  out_result,  mq[0].result);
            chk("out_payload", out_payload, mq[0].payload);
        end
    endtask

    task automatic drive(input bit v, input bit need, input logic [4:0] lop,
                         input logic [31:0] res, input bit dok,
                         input logic [31:0] rd, input bit oa, input bit fl);
        in_valid     = v;
        in_need_resp = need;
        in_load_op   = lop;
        in_result    = res;
        in_payload   = rand_payload();
        data_ok      = dok;
        rdata        = rd;
        out_allowin  = oa;
        flush        = fl;
    endtask

    // Checks current outputs, advances the model by one clock, then the DUT.
    task automatic step();
        int   outst;
        bit   retire;
        bit   accept;
        bit   found;
        ent_t e;
        check_outputs();
        outst = model_outstanding();
        if (flush) begin
            if (data_ok && m_cancel == 0 && outst == 0) m_err = 1'b1;
            m_cancel = m_cancel + outst - (data_ok ? 1 : 0);
            if (m_cancel < 0) m_cancel = 0;
            mq.delete();
        end else begin
            retire = (mq.size() > 0) && (!mq[0].need || mq[0].got) && out_allowin;
            accept = in_valid && (mq.size() < DEPTH);
            if (data_ok) begin
                if (m_cancel > 0) begin
                    m_cancel--;
                end else begin
                    found = 1'b0;
                    foreach (mq[i]) begin
                        if (!found && mq[i].need && !mq[i].got) begin
                            found     = 1'b1;
                            mq[i].got = 1'b1;
                            if (mq[i].lop != 0)
                                mq[i].result = fmt(rdata, int'(mq[i].result[1:0]), mq[i].lop);
                        end
                    end
                    if (!found) m_err = 1'b1;
                end
            end
            if (retire) void'(mq.pop_front());
            if (accept) begin
                e.payload = in_payload;
                e.need    = in_need_resp;
                e.lop     = in_load_op;
                e.result  = in_result;
                e.got     = 1'b0;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input bit oa);
        drive(0, 0, 5'b0, 32'h0, 0, 32'h0, oa, 0);
        step();
    endtask

    task automatic model_reset();
        mq.delete();
        m_cancel = 0;
        m_err    = 1'b0;
    endtask

    initial begin
        int kind;
        bit v, need, dok, oa, fl;
        logic [4:0]  lop;
        logic [31:0] res;

        checks = 0;
        errors = 0;
        model_reset();
        resetn = 1'b0;
        drive(0, 0, 5'b0, 32'h0, 0, 32'h0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        check_outputs();
        resetn = 1'b1;
        @(negedge clk);

        // ld.b off=3 then ld.bu off=3 on the same word
        drive(1, 1, 5'b00001 << LD_B, 32'h1000_0003, 0, 32'h0, 0, 0); step();
        idle(0);
        drive(0, 0, 5'b0, 32'h0, 1, 32'h80FF_0000, 0, 0); step();
        chk("t1_ldb_valid",  out_valid,  1'b1);
        chk("t1_ldb_result", out_result, 32'hFFFF_FF80);
        idle(1);
        drive(1, 1, 5'b00001 << LD_BU, 32'h1000_0003, 0, 32'h0, 0, 0); step();
        drive(0, 0, 5'b0, 32'h0, 1, 32'h80FF_0000, 0, 0); step();
        chk("t1_ldbu_result", out_result, 32'h0000_0080);
        idle(1);

        // Four loads fill the queue; fifth is refused; responses drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 5'b00001 << LD_W, 32'h2000_0000 + 32'(i * 4), 0, 32'h0, 0, 0);
            step();
        end
        chk("t2_full_allowin", in_allowin, 1'b0);
        chk("t2_full_count",   count,      4);
        drive(1, 1, 5'b00001 << LD_W, 32'h2000_0010, 0, 32'h0, 0, 0); step();
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 5'b0, 32'h0, 1, 32'hA000_0000 + 32'(i), 1, 0);
            step();
        end
        idle(1);
        chk("t2_drained", count, 0);

        // ALU, load, ALU: first ALU retires, load blocks the second ALU
        drive(1, 0, 5'b0, 32'h0000_1111, 0, 32'h0, 0, 0); step();
        drive(1, 1, 5'b00001 << LD_H, 32'h3000_0002, 0, 32'h0, 0, 0); step();
        drive(1, 0, 5'b0, 32'h0000_2222, 0, 32'h0, 1, 0); step();
        idle(1);
        idle(1);
        chk("t3_blocked", count, 2);
        drive(0, 0, 5'b0, 32'h0, 1, 32'h8001_1234, 1, 0); step();
        chk("t3_ldh_result", out_result, 32'hFFFF_8001);
        idle(1);
        idle(1);

        // Two pending loads flushed; their responses are swallowed
        drive(1, 1, 5'b00001 << LD_W, 32'h4000_0000, 0, 32'h0, 0, 0); step();
        drive(1, 1, 5'b00001 << LD_W, 32'h4000_0004, 0, 32'h0, 0, 0); step();
        drive(0, 0, 5'b0, 32'h0, 0, 32'h0, 0, 1); step();
        chk("t4_cancel_busy", cancel_busy, 1'b1);
        drive(1, 1, 5'b00001 << LD_W, 32'h4000_0008, 1, 32'hDEAD_0001, 0, 0); step();
        drive(0, 0, 5'b0, 32'h0, 1, 32'hDEAD_0002, 0, 0); step();
        drive(0, 0, 5'b0, 32'h0, 1, 32'hBEEF_0003, 0, 0); step();
        chk("t4_new_result", out_result, 32'hBEEF_0003);
        idle(1);

        // Flush coinciding with data_ok, three pending
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'b00001 << LD_W, 32'h5000_0000, 0, 32'h0, 0, 0);
            step();
        end
        drive(0, 0, 5'b0, 32'h0, 1, 32'h1, 0, 1); step();
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 5'b0, 32'h0, 1, 32'h2, 0, 0);
            step();
        end
        chk("t5_cancel_done", cancel_busy, 1'b0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            v    = $urandom_range(0, 99) < 60;
            kind = $urandom_range(0, 7);
            res  = $urandom();
            if (kind <= 4) begin
                lop  = 5'b00001 << kind;
                need = 1'b1;
                if (kind == LD_H || kind == LD_HU) res[0] = 1'b0;
                if (kind == LD_W) res[1:0] = 2'b00;
            end else begin
                lop  = 5'b0;
                need = (kind == 5);
            end
            dok = (model_outstanding() + m_cancel > 0) && ($urandom_range(0, 99) < 40);
            fl  = ($urandom_range(0, 99) < 3) && (m_cancel <= DEPTH - 1);
            oa  = $urandom_range(0, 99) < 70;
            drive(v, need, lop, res, dok, $urandom(), oa, fl);
            step();
        end

        // Spurious response then asynchronous reset mid-run
        drive(0, 0, 5'b0, 32'h0, 0, 32'h0, 0, 1); step();
        for (int i = 0; i < 8; i++) begin
            dok = m_cancel > 0;
            drive(0, 0, 5'b0, 32'h0, dok, 32'h0, 1, 0);
            step();
        end
        drive(0, 0, 5'b0, 32'h0, 1, 32'h1234_5678, 1, 0); step();
        chk("t6_spurious", err_spurious, 1'b1);
        idle(1);
        drive(1, 1, 5'b00001 << LD_W, 32'h6000_0000, 0, 32'h0, 0, 0); step();
        drive(1, 1, 5'b00001 << LD_W, 32'h6000_0004, 0, 32'h0, 0, 0); step();
        drive(1, 0, 5'b0, 32'h6000_0008, 0, 32'h0, 0, 1); step();
        chk("t6_cancel_before_reset", cancel_busy, 1'b1);
        drive(1, 0, 5'b0, 32'h0, 0, 32'h0, 0, 0);
        resetn = 1'b0;
        #1;
        model_reset();
        chk("t6_rst_count",   count,        0);
        chk("t6_rst_valid",   out_valid,    1'b0);
        chk("t6_rst_allowin", in_allowin,   1'b1);
        chk("t6_rst_cancel",  cancel_busy,  1'b0);
        chk("t6_rst_err",     err_spurious, 1'b0);
        chk("t6_rst_result",  out_result,   0);
        @(negedge clk);
        resetn = 1'b1;
        idle(1);
        check_outputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
